// File: rtl/fetch_pair_pkg.sv
// fetch_pair_pkg: shared constants, F2 bundle record and BTB sizing helper
// for the fetch_pair slice.
package fetch_pair_pkg;

    localparam logic [31:0] NOP             = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;
    localparam int          DEF_BTB_ENTRIES = 16;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        fetched_0;
        logic        fetched_1;
        logic        taken_0;
        logic        taken_1;
    } f2_t;

    function automatic int btb_idx_w(input int entries);
        return $clog2(entries);
    endfunction

endpackage

// File: rtl/fetch_btb.sv
// fetch_btb: direct-mapped branch target buffer with two lookup ports and one
// write/invalidate port; only the valid bits are reset.
module fetch_btb
    import fetch_pair_pkg::*;
#(
    parameter int ENTRIES = DEF_BTB_ENTRIES
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic [31:2] rd0_pc_i,
    input  logic [31:2] rd1_pc_i,
    output logic        rd0_hit_o,
    output logic        rd1_hit_o,
    output logic [31:0] rd0_target_o,
    output logic [31:0] rd1_target_o,
    input  logic        wr_valid_i,
    input  logic        wr_taken_i,
    input  logic [31:2] wr_pc_i,
    input  logic [31:0] wr_target_i,
    input  logic        inv_valid_i,
    input  logic [31:2] inv_pc_i
);

    localparam int IW = btb_idx_w(ENTRIES);
    localparam int TW = 30 - IW;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TW-1:0]      tag_q [ENTRIES];
    logic [TW-1:0]      tag_d [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [IW-1:0]      rd0_idx, rd1_idx, wr_idx, inv_idx;

    assign rd0_idx = rd0_pc_i[IW+1:2];
    assign rd1_idx = rd1_pc_i[IW+1:2];
    assign wr_idx  = wr_pc_i[IW+1:2];
    assign inv_idx = inv_pc_i[IW+1:2];

    assign rd0_hit_o    = valid_q[rd0_idx] && (tag_q[rd0_idx] == rd0_pc_i[31:IW+2]);
    assign rd1_hit_o    = valid_q[rd1_idx] && (tag_q[rd1_idx] == rd1_pc_i[31:IW+2]);
    assign rd0_target_o = target_q[rd0_idx];
    assign rd1_target_o = target_q[rd1_idx];

    // Invalidate is applied first so a same-index update overrides it.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (inv_valid_i)
            valid_d[inv_idx] = 1'b0;
        if (wr_valid_i) begin
            valid_d[wr_idx]  = wr_taken_i;
            tag_d[wr_idx]    = wr_pc_i[31:IW+2];
            target_d[wr_idx] = wr_target_i;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i)
            valid_q <= '0;
        else
            valid_q <= valid_d;
    end

    always_ff @(posedge clock_i) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

endmodule

// File: rtl/fetch_pair.sv
// fetch_pair: dual-issue fetch stage producing aligned instruction pairs for decode.
// Define FETCH_BTB_EN to add the fetch_btb branch predictor.
module fetch_pair
    import fetch_pair_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
    parameter int          BTB_ENTRIES = DEF_BTB_ENTRIES
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    output logic [31:0] imem_addr_o,
    output logic        imem_req_o,
    input  logic [63:0] imem_data_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        wasnt_branch_i,
    input  logic [31:0] fixed_pc_i,
    input  logic        upd_valid_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_pc_i,
    input  logic [31:0] upd_target_i,
    output logic [31:0] inst0_o,
    output logic [31:0] inst1_o,
    output logic [31:0] pc_0_o,
    output logic [31:0] pc_1_o,
    output logic        was_fetched_0_o,
    output logic        was_fetched_1_o,
    output logic        pred_taken_0_o,
    output logic        pred_taken_1_o
);

    logic [31:0] pc_q, pc_d, pc_0, target_0, target_1;
    logic        hit_0, hit_1, fetched_0, fetched_1, taken_0, taken_1, wb_ok, flush;
    f2_t         f2_q, f2_d;

    assign pc_0        = {pc_q[31:3], 3'b000};
    assign fetched_0   = !pc_q[2];
    assign taken_0     = fetched_0 && hit_0;
    assign fetched_1   = !taken_0;
    assign taken_1     = fetched_1 && hit_1;
    assign wb_ok       = wasnt_branch_i && !stall_i;
    assign flush       = redirect_i || wb_ok;
    assign imem_addr_o = pc_0;
    assign imem_req_o  = !stall_i || redirect_i;

`ifdef FETCH_BTB_EN
    logic unused_upd_lsbs;
    assign unused_upd_lsbs = ^upd_pc_i[1:0];

    fetch_btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
        .clock_i      (clock_i),
        .reset_n_i    (reset_n_i),
        .rd0_pc_i     (pc_0[31:2]),
        .rd1_pc_i     (pc_0[31:2] + 30'd1),
        .rd0_hit_o    (hit_0),
        .rd1_hit_o    (hit_1),
        .rd0_target_o (target_0),
        .rd1_target_o (target_1),
        .wr_valid_i   (upd_valid_i),
        .wr_taken_i   (upd_taken_i),
        .wr_pc_i      (upd_pc_i[31:2]),
        .wr_target_i  (upd_target_i),
        .inv_valid_i  (wb_ok),
        .inv_pc_i     (fixed_pc_i[31:2])
    );
`else
    logic unused_btb;
    assign unused_btb = ^{upd_valid_i, upd_taken_i, upd_pc_i, upd_target_i, BTB_ENTRIES != 0};
    assign {hit_0, hit_1, target_0, target_1} = '0;
`endif

    always_comb begin
        pc_d = redirect_i ? redirect_pc_i :
               wb_ok      ? fixed_pc_i + 32'd4 :
               stall_i    ? pc_q :
               taken_0    ? target_0 :
               taken_1    ? target_1 : pc_0 + 32'd8;
        f2_d = f2_q;
        if (flush)
            f2_d.valid = 1'b0;
        else if (!stall_i)
            f2_d = '{1'b1, pc_0, fetched_0, fetched_1, taken_0, taken_1};
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pc_q <= RESET_PC;
            f2_q <= '0;
        end else begin
            pc_q <= pc_d;
            f2_q <= f2_d;
        end
    end

    // Memory holds its output while req is low, so data stays paired with F2.
    assign inst0_o         = f2_q.valid ? imem_data_i[31:0]  : NOP;
    assign inst1_o         = f2_q.valid ? imem_data_i[63:32] : NOP;
    assign pc_0_o          = f2_q.valid ? f2_q.pc : '0;
    assign pc_1_o          = f2_q.valid ? f2_q.pc + 32'd4 : '0;
    assign was_fetched_0_o = f2_q.valid && f2_q.fetched_0;
    assign was_fetched_1_o = f2_q.valid && f2_q.fetched_1;
    assign pred_taken_0_o  = f2_q.valid && f2_q.taken_0;
    assign pred_taken_1_o  = f2_q.valid && f2_q.taken_1;

endmodule

// File: tb/tb_fetch_pair.sv
// tb_fetch_pair: directed scoreboard bench for fetch_pair; BTB cases run when
// FETCH_BTB_EN is defined.
module tb_fetch_pair;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr_o;
    logic        imem_req_o;
    logic [63:0] imem_data_i = '0;
    logic        stall_i, redirect_i, wasnt_branch_i, upd_valid_i, upd_taken_i;
    logic [31:0] redirect_pc_i, fixed_pc_i, upd_pc_i, upd_target_i;
    logic [31:0] inst0_o, inst1_o, pc_0_o, pc_1_o;
    logic        was_fetched_0_o, was_fetched_1_o, pred_taken_0_o, pred_taken_1_o;

    typedef struct packed {
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic        wf0;
        logic        wf1;
        logic        pt0;
        logic        pt1;
        logic [31:0] i0;
        logic [31:0] i1;
    } bun_t;

    bun_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    fetch_pair #(.RESET_PC(32'h0000_0100), .BTB_ENTRIES(16)) dut (
        .clock_i         (clk),
        .reset_n_i       (rst_n),
        .imem_addr_o     (imem_addr_o),
        .imem_req_o      (imem_req_o),
        .imem_data_i     (imem_data_i),
        .stall_i         (stall_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .wasnt_branch_i  (wasnt_branch_i),
        .fixed_pc_i      (fixed_pc_i),
        .upd_valid_i     (upd_valid_i),
        .upd_taken_i     (upd_taken_i),
        .upd_pc_i        (upd_pc_i),
        .upd_target_i    (upd_target_i),
        .inst0_o         (inst0_o),
        .inst1_o         (inst1_o),
        .pc_0_o          (pc_0_o),
        .pc_1_o          (pc_1_o),
        .was_fetched_0_o (was_fetched_0_o),
        .was_fetched_1_o (was_fetched_1_o),
        .pred_taken_0_o  (pred_taken_0_o),
        .pred_taken_1_o  (pred_taken_1_o)
    );

    function automatic logic [31:0] mword(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
    endfunction

    always @(posedge clk)
        if (imem_req_o)
            imem_data_i <= {mword(imem_addr_o + 32'd4), mword(imem_addr_o)};

    task automatic push(input logic [31:0] pc, input logic wf0, input logic wf1,
                        input logic pt0, input logic pt1);
        exp_q.push_back('{pc, pc + 32'd4, wf0, wf1, pt0, pt1, mword(pc), mword(pc + 32'd4)});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && (was_fetched_0_o || was_fetched_1_o) && !stall_i) begin
            bun_t act, e;
            act = '{pc_0_o, pc_1_o, was_fetched_0_o, was_fetched_1_o,
                    pred_taken_0_o, pred_taken_1_o, inst0_o, inst1_o};
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL bundle: unexpected bundle at pc %h", pc_0_o);
            end else begin
                e = exp_q.pop_front();
                if (act === e)
                    passed++;
                else
                    $display("FAIL bundle: got %h, want %h", act, e);
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        {stall_i, redirect_i, wasnt_branch_i, upd_valid_i, upd_taken_i} = '0;
        {redirect_pc_i, fixed_pc_i, upd_pc_i, upd_target_i} = '0;
        #1 rst_n = 1'b0;
        step();
        step();
        chk("rst_addr", imem_addr_o, 32'h100);
        chk("rst_pc0", pc_0_o, 32'h0);
        chk("rst_pc1", pc_1_o, 32'h0);
        chk("rst_inst0", inst0_o, 32'h0000_0013);
        chk("rst_inst1", inst1_o, 32'h0000_0013);
        chk("rst_flags", {28'd0, was_fetched_0_o, was_fetched_1_o, pred_taken_0_o, pred_taken_1_o}, 32'h0);
        push(32'h100, 1, 1, 0, 0);
        push(32'h108, 1, 1, 0, 0);
        rst_n = 1'b1;
        step();
        step();
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc0", pc_0_o, 32'h108);
            chk("stall_addr", imem_addr_o, 32'h110);
            chk("stall_inst0", inst0_o, mword(32'h108));
        end
        stall_i = 1'b0;
        push(32'h110, 1, 1, 0, 0);
        step();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h204;
        push(32'h200, 0, 1, 0, 0);
        step();
        redirect_i = 1'b0;
        chk("redir_addr", imem_addr_o, 32'h200);
        chk("redir_flush", {30'd0, was_fetched_0_o, was_fetched_1_o}, 32'h0);
        push(32'h208, 1, 1, 0, 0);
        step();
        chk("unaligned_pc0", pc_0_o, 32'h200);
        chk("unaligned_wf", {30'd0, was_fetched_0_o, was_fetched_1_o}, 32'h1);
        step();
        step();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h400;
        stall_i = 1'b1;
        step();
        redirect_i = 1'b0;
        stall_i = 1'b0;
        chk("redir_stall_addr", imem_addr_o, 32'h400);
        chk("redir_stall_flush", {30'd0, was_fetched_0_o, was_fetched_1_o}, 32'h0);
        push(32'h400, 1, 1, 0, 0);
        push(32'h408, 1, 1, 0, 0);
        step();
        step();
        wasnt_branch_i = 1'b1;
        fixed_pc_i = 32'h108;
        stall_i = 1'b1;
        step();
        chk("wb_stalled_pc0", pc_0_o, 32'h408);
        chk("wb_stalled_addr", imem_addr_o, 32'h410);
        stall_i = 1'b0;
        push(32'h108, 0, 1, 0, 0);
        step();
        wasnt_branch_i = 1'b0;
        chk("wb_addr", imem_addr_o, 32'h108);
        chk("wb_flush", {30'd0, was_fetched_0_o, was_fetched_1_o}, 32'h0);
        step();
        step();
`ifdef FETCH_BTB_EN
        push(32'h110, 1, 1, 0, 0);
        {upd_valid_i, upd_taken_i} = 2'b11;
        upd_pc_i = 32'h108;
        upd_target_i = 32'h300;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h108;
        step();
        {upd_valid_i, upd_taken_i, redirect_i} = '0;
        push(32'h108, 1, 0, 1, 0);
        push(32'h300, 1, 1, 0, 0);
        step();
        step();
        wasnt_branch_i = 1'b1;
        fixed_pc_i = 32'h108;
        push(32'h108, 0, 1, 0, 0);
        step();
        wasnt_branch_i = 1'b0;
        chk("btb_wb_addr", imem_addr_o, 32'h108);
        step();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h108;
        push(32'h108, 1, 1, 0, 0);
        step();
        redirect_i = 1'b0;
        step();
        step();
        push(32'h110, 1, 1, 0, 0);
        {upd_valid_i, upd_taken_i} = 2'b11;
        upd_pc_i = 32'h11C;
        upd_target_i = 32'h500;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h118;
        push(32'h118, 1, 1, 0, 1);
        push(32'h500, 1, 1, 0, 0);
        step();
        {upd_valid_i, upd_taken_i, redirect_i} = '0;
        step();
        step();
        step();
`endif
        stall_i = 1'b1;
        step();
        step();
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_addr", imem_addr_o, 32'h100);
        chk("async_rst_pc0", pc_0_o, 32'h0);
        chk("async_rst_wf", {30'd0, was_fetched_0_o, was_fetched_1_o}, 32'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
